// File: rtl/snake_state_engine_if.sv
// snake_state_engine_if: move/start/button strobes in, rendered game-state bundle out
interface snake_state_engine_if;
    logic         Tick;
    logic         Start;
    logic         BtnU;
    logic         BtnD;
    logic         BtnL;
    logic         BtnR;
    logic [127:0] Locations_Flat;
    logic [7:0]   Food;
    logic [3:0]   Length;
    logic         Qw;
    logic         Ql;
    logic         Qc;

    modport master (
        output Tick, Start, BtnU, BtnD, BtnL, BtnR,
        input  Locations_Flat, Food, Length, Qw, Ql, Qc
    );

    modport slave (
        input  Tick, Start, BtnU, BtnD, BtnL, BtnR,
        output Locations_Flat, Food, Length, Qw, Ql, Qc
    );
endinterface

// File: rtl/snake_state_engine.sv
// snake_state_engine: 16x16 snake game core (segments, food, length, win/lose/consume); define WRAP_EN to make walls wrap
module snake_state_engine #(
    parameter int unsigned WIN_LEN   = 15,
    parameter logic [7:0]  START_POS = 8'h77,
    parameter logic [7:0]  FOOD_INIT = 8'h7B,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic Clk,
    input logic Reset,
    snake_state_engine_if.slave bus
);
    typedef enum logic [2:0] {INIT, RUN, CONSUME, WIN, LOSE} state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    state_t     state, state_n;
    dir_t       dir, dir_n, pend, pend_n, req, eff;
    logic [7:0] seg [16];
    logic [7:0] seg_n [16];
    logic [7:0] food, food_n, lfsr, new_head;
    logic [3:0] length, length_n, row, col;
    logic       qw, ql, qc, btn, wall, eat, hit, taken;

    // Free-running food LFSR, x^8+x^6+x^5+x^4+1
    always_ff @(posedge Clk) begin
        if (Reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Button decode, next head cell and collision tests
    always_comb begin
        btn = bus.BtnU | bus.BtnD | bus.BtnL | bus.BtnR;
        req = bus.BtnU ? UP : bus.BtnD ? DOWN : bus.BtnL ? LEFT : RIGHT;
        eff = (state == RUN && bus.Tick) ? pend : dir;
        row = seg[0][7:4];
        col = seg[0][3:0];
        new_head = pend == UP   ? {row - 4'd1, col} :
                   pend == DOWN ? {row + 4'd1, col} :
                   pend == LEFT ? {row, col - 4'd1} : {row, col + 4'd1};
`ifdef WRAP_EN
        wall = 1'b0;
`else
        wall = (pend == UP && row == 4'd0) || (pend == DOWN && row == 4'd15) ||
               (pend == LEFT && col == 4'd0) || (pend == RIGHT && col == 4'd15);
`endif
        eat = new_head == food;
        hit = 1'b0;
        taken = 1'b0;
        // The tail vacates on a plain move, but stays put when the snake grows
        for (int i = 1; i < 16; i++)
            if (seg[i] == new_head && 4'(i) < (eat ? length : length - 4'd1)) hit = 1'b1;
        for (int i = 0; i < 16; i++)
            if (seg[i] == lfsr && 4'(i) < length) taken = 1'b1;
    end

    // Game FSM next state and datapath update; everything holds by default
    always_comb begin
        state_n = state;
        dir_n = dir;
        pend_n = (btn && !(req == dir_t'(eff ^ 2'd1) && length > 4'd1)) ? req : pend;
        seg_n = seg;
        length_n = length;
        food_n = food;
        if (state == INIT) begin
            pend_n = pend;
            if (bus.Start) state_n = RUN;
        end else if (state == RUN) begin
            if (bus.Tick) begin
                dir_n = pend;
                if (wall || hit) state_n = LOSE;
                else begin
                    for (int i = 15; i > 0; i--) seg_n[i] = seg[i-1];
                    seg_n[0] = new_head;
                    if (eat) begin
                        length_n = length + 4'd1;
                        state_n = CONSUME;
                    end
                end
            end
        end else if (state == CONSUME) begin
            food_n = lfsr;
            state_n = taken ? CONSUME : (length == 4'(WIN_LEN) ? WIN : RUN);
        end else begin
            pend_n = pend;
            if (bus.Start) begin
                state_n = INIT;
                dir_n = RIGHT;
                pend_n = RIGHT;
                seg_n = '{default: START_POS};
                length_n = 4'd1;
                food_n = FOOD_INIT;
            end
        end
    end

    // State and datapath registers; status flags are registered copies of the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
            dir <= RIGHT;
            pend <= RIGHT;
            seg <= '{default: START_POS};
            length <= 4'd1;
            food <= FOOD_INIT;
            qw <= 1'b0;
            ql <= 1'b0;
            qc <= 1'b0;
        end else begin
            state <= state_n;
            dir <= dir_n;
            pend <= pend_n;
            seg <= seg_n;
            length <= length_n;
            food <= food_n;
            qw <= state_n == WIN;
            ql <= state_n == LOSE;
            qc <= state_n == CONSUME;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign bus.Locations_Flat[127-8*g -: 8] = seg[g];
    end

    assign bus.Food = food;
    assign bus.Length = length;
    assign bus.Qw = qw;
    assign bus.Ql = ql;
    assign bus.Qc = qc;
endmodule

// File: tb/tb_snake_state_engine.sv
// tb_snake_state_engine: directed scenarios for snake_state_engine with a small game model
module tb_snake_state_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0000;
    int         checks = 0;
    int         fails = 0;
    logic [7:0] m_seg [16];
    logic [7:0] m_food;
    logic [7:0] lfsr_m;
    logic [3:0] m_len;
    logic [1:0] m_dir;
    logic [1:0] m_pend;
    logic       m_lost;

    snake_state_engine_if bus ();
    snake_state_engine_if bus3 ();

    assign bus.Tick = tick;
    assign bus.Start = start;
    assign bus.BtnU = btn[3];
    assign bus.BtnD = btn[2];
    assign bus.BtnL = btn[1];
    assign bus.BtnR = btn[0];
    assign bus3.Tick = tick;
    assign bus3.Start = start;
    assign bus3.BtnU = btn[3];
    assign bus3.BtnD = btn[2];
    assign bus3.BtnL = btn[1];
    assign bus3.BtnR = btn[0];

    snake_state_engine dut (.Clk(clk), .Reset(rst), .bus(bus));
    snake_state_engine #(.WIN_LEN(3)) dut3 (.Clk(clk), .Reset(rst), .bus(bus3));

    always #5 clk = ~clk;

    always @(posedge clk) lfsr_m <= rst ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    function automatic logic [7:0] seg_at(input int i);
        return bus.Locations_Flat[127-8*i -: 8];
    endfunction

    function automatic logic in_segs(input logic [7:0] v);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 16; i++) if (i < int'(m_len) && m_seg[i] == v) f = 1'b1;
        return f;
    endfunction

    task automatic model_init;
        for (int i = 0; i < 16; i++) m_seg[i] = 8'h77;
        m_len = 4'd1;
        m_dir = 2'd3;
        m_pend = 2'd3;
        m_food = 8'h7B;
        m_lost = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick = 1'b0;
        start = 1'b0;
        btn = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_init();
    endtask

    task automatic start_game;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One button cycle (b = {U,D,L,R}, may be zero) followed by one Tick, then model comparison
    task automatic step(input logic [3:0] b);
        logic [1:0] req, d;
        logic [3:0] r, c;
        logic [7:0] nh, pick;
        logic wall, hit, ate, busy;
        int bad;
        ate = 1'b0;
        btn = b;
        @(negedge clk);
        btn = 4'b0000;
        if (!m_lost && b != 4'b0000) begin
            req = b[3] ? 2'd0 : b[2] ? 2'd1 : b[1] ? 2'd2 : 2'd3;
            if (!(req == (m_dir ^ 2'd1) && m_len > 4'd1)) m_pend = req;
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        if (!m_lost) begin
            d = m_pend;
            m_dir = d;
            r = m_seg[0][7:4];
            c = m_seg[0][3:0];
            wall = (d == 2'd0 && r == 4'd0) || (d == 2'd1 && r == 4'd15) || (d == 2'd2 && c == 4'd0) || (d == 2'd3 && c == 4'd15);
`ifdef WRAP_EN
            wall = 1'b0;
`endif
            r = d == 2'd0 ? r - 4'd1 : d == 2'd1 ? r + 4'd1 : r;
            c = d == 2'd2 ? c - 4'd1 : d == 2'd3 ? c + 4'd1 : c;
            nh = {r, c};
            ate = nh == m_food;
            hit = 1'b0;
            for (int i = 1; i < 16; i++) if (m_seg[i] == nh && i < (ate ? int'(m_len) : int'(m_len) - 1)) hit = 1'b1;
            if (wall || hit) begin
                m_lost = 1'b1;
                ate = 1'b0;
            end else begin
                for (int i = 15; i > 0; i--) m_seg[i] = m_seg[i-1];
                m_seg[0] = nh;
                if (ate) m_len = m_len + 4'd1;
            end
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && i < int'(m_len) && seg_at(i) !== m_seg[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL step_seg[%0d]: got %h expected %h", bad, seg_at(bad), m_seg[bad]);
        end
        checks++;
        if (bus.Length !== m_len) begin
            fails++;
            $display("FAIL step_length: got %0d expected %0d", bus.Length, m_len);
        end
        checks++;
        if ({bus.Qw, bus.Ql, bus.Qc} !== {1'b0, m_lost, ate}) begin
            fails++;
            $display("FAIL step_flags(QwQlQc): got %b expected %b", {bus.Qw, bus.Ql, bus.Qc}, {1'b0, m_lost, ate});
        end
        busy = ate;
        for (int n = 0; busy && n < 64; n++) begin
            pick = lfsr_m;
            busy = in_segs(pick);
            @(negedge clk);
            m_food = pick;
            checks++;
            if (bus.Qc !== busy) begin
                fails++;
                $display("FAIL consume_qc: got %b expected %b", bus.Qc, busy);
            end
        end
        checks++;
        if (bus.Food !== m_food || in_segs(bus.Food)) begin
            fails++;
            $display("FAIL step_food: got %h expected %h (must be off the snake)", bus.Food, m_food);
        end
    endtask

    task automatic test_reset;
        logic [127:0] all_start;
        all_start = {16{8'h77}};
        do_reset();
        checks++;
        if (bus.Locations_Flat !== all_start) begin
            fails++;
            $display("FAIL reset_segs: got %h expected %h", bus.Locations_Flat, all_start);
        end
        checks++;
        if (bus.Length !== 4'd1 || bus.Food !== 8'h7B) begin
            fails++;
            $display("FAIL reset_len_food: got %0d/%h expected 1/7b", bus.Length, bus.Food);
        end
        checks++;
        if ({bus.Qw, bus.Ql, bus.Qc} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000", {bus.Qw, bus.Ql, bus.Qc});
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checks++;
        if (seg_at(0) !== 8'h77) begin
            fails++;
            $display("FAIL init_ignores_tick: got %h expected 77", seg_at(0));
        end
    endtask

    task automatic test_move_and_food;
        logic [7:0] exp_heads [3];
        exp_heads = '{8'h78, 8'h79, 8'h7A};
        do_reset();
        start_game();
        checks++;
        if ({bus.Qw, bus.Ql, bus.Qc} !== 3'b000) begin
            fails++;
            $display("FAIL run_flags: got %b expected 000", {bus.Qw, bus.Ql, bus.Qc});
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0000);
            checks++;
            if (seg_at(0) !== exp_heads[i]) begin
                fails++;
                $display("FAIL move_head[%0d]: got %h expected %h", i, seg_at(0), exp_heads[i]);
            end
        end
        step(4'b0000);
        checks++;
        if (seg_at(0) !== 8'h7B || bus.Length !== 4'd2) begin
            fails++;
            $display("FAIL eat_head_len: got %h/%0d expected 7b/2", seg_at(0), bus.Length);
        end
        step(4'b0010);
        checks++;
        if (seg_at(0) !== 8'h7C) begin
            fails++;
            $display("FAIL reverse_ignored: got %h expected 7c", seg_at(0));
        end
    endtask

    task automatic test_reset_mid_consume;
        do_reset();
        start_game();
        repeat (3) step(4'b0000);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checks++;
        if (bus.Qc !== 1'b1) begin
            fails++;
            $display("FAIL consume_entry: got Qc=%b expected 1", bus.Qc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_init();
        checks++;
        if (bus.Qc !== 1'b0 || bus.Length !== 4'd1 || seg_at(0) !== 8'h77 || bus.Food !== 8'h7B) begin
            fails++;
            $display("FAIL reset_in_consume: got Qc=%b len=%0d head=%h food=%h expected 0/1/77/7b", bus.Qc, bus.Length, seg_at(0), bus.Food);
        end
    endtask

    task automatic test_wall;
        logic [7:0] exp_head;
        logic exp_ql;
        exp_head = 8'h07;
        exp_ql = 1'b1;
`ifdef WRAP_EN
        exp_head = 8'hF7;
        exp_ql = 1'b0;
`endif
        do_reset();
        start_game();
        step(4'b1000);
        repeat (7) step(4'b0000);
        checks++;
        if (seg_at(0) !== exp_head || bus.Ql !== exp_ql) begin
            fails++;
            $display("FAIL wall: got head=%h Ql=%b expected %h/%b", seg_at(0), bus.Ql, exp_head, exp_ql);
        end
        if (m_lost) begin
            step(4'b0100);
            start_game();
            model_init();
            checks++;
            if (bus.Ql !== 1'b0 || seg_at(0) !== 8'h77 || bus.Length !== 4'd1) begin
                fails++;
                $display("FAIL restart: got Ql=%b head=%h len=%0d expected 0/77/1", bus.Ql, seg_at(0), bus.Length);
            end
        end
    endtask

    task automatic test_direction;
        do_reset();
        start_game();
        step(4'b0010);
        checks++;
        if (seg_at(0) !== 8'h76) begin
            fails++;
            $display("FAIL len1_reverse: got %h expected 76", seg_at(0));
        end
        do_reset();
        start_game();
        step(4'b1001);
        checks++;
        if (seg_at(0) !== 8'h67) begin
            fails++;
            $display("FAIL btn_priority: got %h expected 67", seg_at(0));
        end
        start_game();
        step(4'b0000);
        checks++;
        if (seg_at(0) !== 8'h57) begin
            fails++;
            $display("FAIL start_in_run: got %h expected 57", seg_at(0));
        end
    endtask

    task automatic test_grow_win_self_hit;
        logic [7:0] h;
        logic [1:0] want, d, p;
        logic won_seen;
        won_seen = 1'b0;
        do_reset();
        start_game();
        for (int n = 0; n < 300 && m_len < 4'd5 && !m_lost; n++) begin
            h = m_seg[0];
            want = h[3:0] != m_food[3:0] ? (m_food[3:0] > h[3:0] ? 2'd3 : 2'd2) : (m_food[7:4] > h[7:4] ? 2'd1 : 2'd0);
            if (want == (m_dir ^ 2'd1)) want = want[1] ? (h[7:4] != 4'd0 ? 2'd0 : 2'd1) : (h[3:0] != 4'd0 ? 2'd2 : 2'd3);
            step(4'b1000 >> want);
            if (m_len == 4'd3 && !won_seen) begin
                won_seen = 1'b1;
                checks++;
                if (bus3.Qw !== 1'b1 || bus3.Ql !== 1'b0 || bus3.Length !== 4'd3) begin
                    fails++;
                    $display("FAIL win_len3: got Qw=%b Ql=%b len=%0d expected 1/0/3", bus3.Qw, bus3.Ql, bus3.Length);
                end
            end
        end
        checks++;
        if (bus.Length !== 4'd5) begin
            fails++;
            $display("FAIL grow_to_5: got %0d expected 5", bus.Length);
        end
        d = m_dir;
        p = d[1] ? (m_seg[0][7:4] != 4'd0 ? 2'd0 : 2'd1) : (m_seg[0][3:0] != 4'd0 ? 2'd2 : 2'd3);
        step(4'b1000 >> p);
        step(4'b1000 >> (d ^ 2'd1));
        step(4'b1000 >> (p ^ 2'd1));
        checks++;
        if (bus.Ql !== 1'b1) begin
            fails++;
            $display("FAIL self_hit: got Ql=%b expected 1", bus.Ql);
        end
    endtask

    initial begin
        test_reset();
        test_move_and_food();
        test_reset_mid_consume();
        test_wall();
        test_direction();
        test_grow_win_self_hit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/snake_state_engine.md
Name: snake_state_engine

Overview:
Game-state core for the snake game. It holds segment positions, food position, length and game status on a 16x16 cell grid. It advances the snake one cell per move tick and detects food, wall and self collisions. It produces the Locations_Flat / Food / Length / Qw / Ql / Qc bundle that the VGA renderer consumes.

Parameters:
WIN_LEN, 15, length at which the game is won (2..15)
START_POS, 8'h77, head cell after init (row 7, col 7)
FOOD_INIT, 8'h7B, food cell after init
LFSR_SEED, 8'hA5, nonzero seed for the food LFSR

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Tick  in  1  single-cycle move strobe (slow game rate)
Start  in  1  single-cycle pulse; starts or restarts the game
BtnU, BtnD, BtnL, BtnR  in  1 each  direction request pulses
Locations_Flat  out  128  16 segments x 8 bits; segment 0 (head) in [127:120], segment i in [127-8i -: 8]; cell = row*16 + col
Food  out  8  food cell
Length  out  4  active segment count
Qw  out  1  win state
Ql  out  1  lose state
Qc  out  1  consume state (food eaten, new food being placed)

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - All segments = START_POS; Length = 1; Food = FOOD_INIT.
  - Direction = RIGHT; pending direction = RIGHT.
  - Qw = Ql = Qc = 0; state = INIT; LFSR = LFSR_SEED.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Steps every cycle in every state. It is never 0.
- Direction latch:
  - Any Btn pulse updates the pending direction. Simultaneous presses resolve by priority U > D > L > R.
  - A request exactly opposite the current direction is ignored, but only while Length > 1.
- States:
  - INIT: outputs at reset values. Start -> RUN (1 cycle).
  - RUN, on Tick:
    - Commit pending direction to direction.
    - new_head = head +/-1 (col) or +/-16 (row).
    - Wall hit (col 0 moving L, col 15 moving R, row 0 moving U, row 15 moving D) -> LOSE. Segments unchanged.
    - Self hit: new_head equals segment i for 1 <= i <= Length-2 -> LOSE. The tail (Length-1) is not a hit, because it vacates. Exception: if new_head == Food, the tail index Length-1 is also checked.
    - Otherwise: seg[i] <= seg[i-1] for i = 1..15; seg[0] <= new_head.
    - If new_head == Food: Length <= Length+1, then -> CONSUME.
    - RUN without Tick: hold.
  - CONSUME (Qc = 1):
    - Each cycle: Food <= LFSR value.
    - If that value equals any segment with index < Length, stay in CONSUME (re-roll next cycle).
    - Otherwise, if Length == WIN_LEN -> WIN, else -> RUN.
    - A Tick arriving during CONSUME is dropped.
  - WIN (Qw = 1) / LOSE (Ql = 1): all state frozen. Start -> INIT reload (Start in WIN/LOSE acts as restart).
- Status outputs are registered and one-hot with state. In INIT and RUN all three are 0.
- Latency:
  - Segment and Length update 1 cycle after Tick.
  - Qc, Ql and Qw assert 1 cycle after the causing Tick.
- Arithmetic: row and col are 4-bit fields. Moves never carry between fields; wall detection runs before the add.
- Segments at index >= Length continue to shift. Their values are don't-care for consumers.
- Start during RUN or CONSUME is ignored.
- Reset has priority over all events, including mid-CONSUME.

Optional Feature:
WRAP_EN:
- Defined: walls wrap. Moving L from col 0 gives col 15, moving D from row 15 gives row 0, and so on. Wall loss is removed; self collision is still checked.
- Undefined: wall hit -> LOSE, as in Behaviour.

Test Plan:
- Reset, Start, 3 Ticks (no buttons) -> head 8'h77 -> 78 -> 79 -> 7A; Length = 1; Ql = Qw = Qc = 0.
- Reset, Start, 4 Ticks with FOOD_INIT 8'h7B -> 4th Tick yields head 7B, Length = 2, Qc = 1 next cycle. Food ends != any active segment; state returns to RUN.
- Reset, Start, BtnU then 8 Ticks -> head row 0 after 7 Ticks (8'h07). 8th Tick -> Ql = 1, segments frozen; a Start pulse returns to INIT with head 77. With WRAP_EN: head 8'hF7, Ql = 0.
- Length = 1 moving R, BtnL then Tick -> direction changes, head 76. Length = 3 moving R, BtnL then Tick -> ignored, head moves R.
- BtnU and BtnR in the same cycle, then Tick -> direction UP.
- Preload a length-5 snake in a square loop (U, L, D turns) -> next Tick lands on segment 3 -> Ql = 1. Separately, WIN_LEN = 3 with food placed twice -> Qw = 1 after the second CONSUME.
